// File: rtl/vga_draw_arbiter.sv
// vga_draw_arbiter
// Shares the single VGA adapter write port among three drawing clients
// (0 = screen clear, 1 = board/tile drawer, 2 = score-bar drawer).
// Round-robin grant with a req/done handshake, a registered output mux,
// a mandatory one-cycle gap between grants and a hold watchdog that
// revokes a client which never lets go of the port.

module vga_draw_arbiter #(
    parameter int MAX_HOLD = 20000,  // longest grant in cycles; a full 160x120 clear fits
    parameter int CNT_W    = 16      // hold counter width, 2**CNT_W > MAX_HOLD
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  req,
    input  logic [2:0]  done,
    input  logic [23:0] x_in,
    input  logic [20:0] y_in,
    input  logic [8:0]  color_in,
    input  logic [2:0]  plot_in,
    output logic [2:0]  grant,
    output logic [7:0]  vga_x,
    output logic [6:0]  vga_y,
    output logic [2:0]  vga_color,
    output logic        vga_plot,
    output logic        busy,
    output logic        timeout
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    // Last hold count at which the grant may still be kept; reaching it
    // without a release revokes the grant at the following edge.
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_t           state_q;
    logic [2:0]       grant_q;
    logic [1:0]       gidx_q;     // index of the granted client
    logic [1:0]       last_q;     // most recently released client
    logic [CNT_W-1:0] hold_q;
    logic [7:0]       vga_x_q;
    logic [6:0]       vga_y_q;
    logic [2:0]       vga_color_q;
    logic             vga_plot_q;
    logic             timeout_q;

    // Slice of the granted client, and next-state helpers
    logic [7:0]       sel_x;
    logic [6:0]       sel_y;
    logic [2:0]       sel_color;
    logic             sel_plot;
    logic             sel_done;
    logic             sel_req;
    logic [1:0]       pick_d;
    logic [2:0]       grant_d;
    logic [CNT_W-1:0] hold_d;
    logic             release_d;
    logic             watchdog_d;

    // Select the granted client's pixel and handshake bits.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path through the case leaves a value unassigned (no latch).
        sel_x     = '0;
        sel_y     = '0;
        sel_color = '0;
        sel_plot  = 1'b0;
        sel_done  = 1'b0;
        sel_req   = 1'b0;
        case (gidx_q)
            2'd0: begin
                sel_x     = x_in[7:0];
                sel_y     = y_in[6:0];
                sel_color = color_in[2:0];
                sel_plot  = plot_in[0];
                sel_done  = done[0];
                sel_req   = req[0];
            end
            2'd1: begin
                sel_x     = x_in[15:8];
                sel_y     = y_in[13:7];
                sel_color = color_in[5:3];
                sel_plot  = plot_in[1];
                sel_done  = done[1];
                sel_req   = req[1];
            end
            2'd2: begin
                sel_x     = x_in[23:16];
                sel_y     = y_in[20:14];
                sel_color = color_in[8:6];
                sel_plot  = plot_in[2];
                sel_done  = done[2];
                sel_req   = req[2];
            end
            default: ;
        endcase
    end

    // Round-robin pick: first requester after the last released client.
    always_comb begin
        pick_d = 2'd0;
        case (last_q)
            2'd0:    pick_d = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
            2'd1:    pick_d = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
            default: pick_d = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
        endcase
        grant_d    = 3'b001 << pick_d;
        hold_d     = hold_q + CNT_W'(1);
        release_d  = sel_done | ~sel_req;
        watchdog_d = (hold_q == HOLD_LAST);
    end

    // Arbiter FSM with registered grant, pixel path and status outputs.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the values from before this edge.
        if (reset) begin
            state_q     <= S_IDLE;
            grant_q     <= 3'b000;
            gidx_q      <= 2'd0;
            last_q      <= 2'd2;
            hold_q      <= '0;
            vga_x_q     <= '0;
            vga_y_q     <= '0;
            vga_color_q <= '0;
            vga_plot_q  <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    vga_plot_q <= 1'b0;
                    if (|req) begin
                        grant_q <= grant_d;
                        gidx_q  <= pick_d;
                        hold_q  <= '0;
                        state_q <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    // The pixel of the current cycle is forwarded even on release.
                    vga_x_q     <= sel_x;
                    vga_y_q     <= sel_y;
                    vga_color_q <= sel_color;
                    vga_plot_q  <= sel_plot;
                    if (release_d || watchdog_d) begin
                        grant_q   <= 3'b000;
                        last_q    <= gidx_q;
                        hold_q    <= '0;
                        state_q   <= S_GAP;
                        // A release in the watchdog cycle wins: no timeout pulse.
                        timeout_q <= ~release_d;
                    end else begin
                        hold_q <= hold_d;
                    end
                end
                S_GAP: begin
                    vga_plot_q <= 1'b0;
                    grant_q    <= 3'b000;
                    state_q    <= S_IDLE;
                end
                default: begin
                    vga_plot_q <= 1'b0;
                    grant_q    <= 3'b000;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

    assign grant     = grant_q;
    assign vga_x     = vga_x_q;
    assign vga_y     = vga_y_q;
    assign vga_color = vga_color_q;
    assign vga_plot  = vga_plot_q;
    assign busy      = (state_q != S_IDLE);
    assign timeout   = timeout_q;

endmodule
